// File: rtl/counter_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : counter_cfg_seq
//  Purpose  : Command sequencer for a single counter_block register bus.
//             Takes one command at a time over a valid/ready handshake. It
//             expands each command into the cs/wr/rd strobe sequence that the
//             counter block expects. READ results are assembled low byte
//             first into a WIDTH-bit response.
//  Ports    : busclk, busrst_n (sync, active low)
//             cmd_valid/cmd_ready/cmd_op/cmd_mask/cmd_value/cmd_route : command
//             rsp_valid/rsp_value/busy                                : status
//             cb_cs/cb_wr/cb_rd/cb_adr/cb_data_in/cb_data_out/
//             cb_wide_data/cb_route_con                               : counter bus
//  Revision : 1.0  initial release
// ============================================================================
module counter_cfg_seq #(
  parameter int WIDTH      = 16,
  parameter int NUM_ROUTES = 16,
  parameter int HOLD       = 2,
  parameter int GAP        = 2,
  parameter int RD_WAIT    = 2
) (
  input  logic                  busclk,
  input  logic                  busrst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [7:0]            cmd_mask,
  input  logic [WIDTH-1:0]      cmd_value,
  input  logic [NUM_ROUTES-1:0] cmd_route,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_value,
  output logic                  busy,
  output logic                  cb_cs,
  output logic                  cb_wr,
  output logic                  cb_rd,
  output logic [1:0]            cb_adr,
  output logic [7:0]            cb_data_in,
  input  logic [7:0]            cb_data_out,
  output logic [WIDTH-1:0]      cb_wide_data,
  output logic [NUM_ROUTES-1:0] cb_route_con
);

  localparam int NB    = (WIDTH + 7) / 8;
  localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int MAXC  = (MAXHG > RD_WAIT) ? MAXHG : RD_WAIT;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_CMP        = 3'd2;
  localparam logic [2:0] OP_TRIG_ROUTE = 3'd3;
  localparam logic [2:0] OP_CMP_ROUTE  = 3'd4;
  localparam logic [2:0] OP_PULSE      = 3'd5;
  localparam logic [2:0] OP_READ       = 3'd6;
  localparam logic [2:0] OP_LOAD_START = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_GAP    = 3'd3,
    R_SETUP  = 3'd4,
    R_STROBE = 3'd5,
    R_GAP    = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               second;     // second write of LOAD_START in progress
  logic [1:0]         byte_idx;
  logic [8*NB-1:0]    rd_acc;
  logic               out_en;     // low during reset so every output reads 0
  logic               accept;

  assign cmd_ready = out_en && (state == IDLE);
  assign busy      = out_en && (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Next state and strobes decoded straight from the state register.
  always_comb begin
    state_d   = state;
    cb_cs     = 1'b0;
    cb_wr     = 1'b0;
    cb_rd     = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_NOP)       state_d = DONE;
          else if (cmd_op == OP_READ) state_d = R_SETUP;
          else                        state_d = W_SETUP;
        end
      end
      W_SETUP: state_d = W_STROBE;
      W_STROBE: begin
        cb_cs = 1'b1;
        cb_wr = 1'b1;
        if (cnt == CNT_W'(HOLD - 1)) state_d = W_GAP;
      end
      W_GAP: begin
        if (cnt == CNT_W'(GAP - 1))
          state_d = (op_q == OP_LOAD_START && !second) ? W_SETUP : DONE;
      end
      R_SETUP: state_d = R_STROBE;
      R_STROBE: begin
        cb_cs = 1'b1;
        cb_rd = 1'b1;
        if (cnt == CNT_W'(RD_WAIT - 1)) state_d = R_GAP;
      end
      R_GAP: begin
        if (cnt == CNT_W'(GAP - 1))
          state_d = (byte_idx == 2'(NB - 1)) ? DONE : R_SETUP;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge busclk) begin
    if (!busrst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= OP_NOP;
      second       <= 1'b0;
      byte_idx     <= 2'd0;
      rd_acc       <= '0;
      rsp_value    <= '0;
      cb_adr       <= 2'd0;
      cb_data_in   <= 8'h00;
      cb_wide_data <= '0;
      cb_route_con <= '0;
      out_en       <= 1'b0;
    end else begin
      out_en <= 1'b1;
      state  <= state_d;
      // Dwell counter restarts on every state change, so back-to-back
      // setup/strobe/gap phases each count from zero.
      cnt    <= (state_d != state) ? '0 : cnt + 1'b1;

      // Bus data is loaded on entry to W_SETUP and held through W_GAP, so
      // the counter block sees stable data around its single wr rising edge.
      if (accept) begin
        op_q     <= cmd_op;
        second   <= 1'b0;
        byte_idx <= 2'd0;
        case (cmd_op)
          OP_LOAD, OP_LOAD_START: begin
            cb_adr       <= 2'd0;
            cb_data_in   <= 8'h80;
            cb_wide_data <= cmd_value;
          end
          OP_CMP: begin
            cb_adr       <= 2'd1;
            cb_data_in   <= cmd_mask;
            cb_wide_data <= cmd_value;
          end
          OP_TRIG_ROUTE: begin
            cb_adr       <= 2'd2;
            cb_data_in   <= {3'b000, cmd_mask[4:0]};
            cb_route_con <= cmd_route;
          end
          OP_CMP_ROUTE: begin
            cb_adr       <= 2'd3;
            cb_data_in   <= cmd_mask;
            cb_route_con <= cmd_route;
          end
          OP_PULSE: begin
            cb_adr     <= 2'd0;
            cb_data_in <= {3'b000, cmd_mask[4:0]};
          end
          OP_READ: cb_adr <= 2'd0;
          default: ;
        endcase
      end

      // LOAD_START: follow the load with a load+start write.
      if (state == W_GAP && state_d == W_SETUP) begin
        second     <= 1'b1;
        cb_adr     <= 2'd0;
        cb_data_in <= 8'h09;
      end

      // Sample the read byte on the last strobe cycle.
      if (state == R_STROBE && state_d == R_GAP) begin
        for (int b = 0; b < NB; b++) begin
          if (byte_idx == 2'(b)) rd_acc[8*b +: 8] <= cb_data_out;
        end
      end

      if (state == R_GAP && state_d == R_SETUP) begin
        byte_idx <= byte_idx + 2'd1;
        cb_adr   <= byte_idx + 2'd1;
      end

      if (state == R_GAP && state_d == DONE) rsp_value <= rd_acc[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_cfg_seq
//  Purpose  : Directed self-checking bench for counter_cfg_seq (default
//             parameters). A simple bus model returns 8'hEF at address 0 and
//             8'hBE at address 1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_cfg_seq;

  logic        busclk = 1'b0;
  logic        busrst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_mask;
  logic [15:0] cmd_value;
  logic [15:0] cmd_route;
  logic        rsp_valid;
  logic [15:0] rsp_value;
  logic        busy;
  logic        cb_cs, cb_wr, cb_rd;
  logic [1:0]  cb_adr;
  logic [7:0]  cb_data_in;
  logic [7:0]  cb_data_out;
  logic [15:0] cb_wide_data;
  logic [15:0] cb_route_con;

  always #5 busclk = ~busclk;

  assign cb_data_out = (cb_adr == 2'd1) ? 8'hBE : 8'hEF;

  counter_cfg_seq dut (
    .busclk       (busclk),
    .busrst_n     (busrst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_mask     (cmd_mask),
    .cmd_value    (cmd_value),
    .cmd_route    (cmd_route),
    .rsp_valid    (rsp_valid),
    .rsp_value    (rsp_value),
    .busy         (busy),
    .cb_cs        (cb_cs),
    .cb_wr        (cb_wr),
    .cb_rd        (cb_rd),
    .cb_adr       (cb_adr),
    .cb_data_in   (cb_data_in),
    .cb_data_out  (cb_data_out),
    .cb_wide_data (cb_wide_data),
    .cb_route_con (cb_route_con)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus protocol watch: wr/rd exclusive, cs only with a strobe.
  always @(negedge busclk) begin
    if (busrst_n && ((cb_wr && cb_rd) || (cb_cs && !(cb_wr || cb_rd))))
      viol <= viol + 1;
  end

  // Per-command capture
  logic [63:0] wr_hist, rd_hist;
  logic [7:0]  wdata[$];
  logic [1:0]  radr[$];
  logic [1:0]  s_adr;
  logic [7:0]  s_data;
  logic [15:0] s_wide, s_route;
  logic        s_cs;
  int          rsp_cyc;

  // Issue one command; cycle k is the k-th cycle after the handshake edge.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] mask,
                         input logic [15:0] value, input logic [15:0] route);
    int  guard;
    logic pw, pr;
    guard = 0;
    while (!cmd_ready && guard < 30) begin
      @(posedge busclk); #1;
      guard++;
    end
    cmd_op = op; cmd_mask = mask; cmd_value = value; cmd_route = route;
    cmd_valid = 1'b1;
    @(posedge busclk); #1;
    cmd_valid = 1'b0;
    wr_hist = '0; rd_hist = '0; wdata.delete(); radr.delete();
    rsp_cyc = -1; pw = 1'b0; pr = 1'b0;
    for (int k = 1; k < 64; k++) begin
      if (k == 1) begin
        s_adr = cb_adr; s_data = cb_data_in; s_wide = cb_wide_data;
        s_route = cb_route_con; s_cs = cb_cs;
      end
      wr_hist[k] = cb_cs && cb_wr;
      rd_hist[k] = cb_cs && cb_rd;
      if (cb_cs && cb_wr && !pw) wdata.push_back(cb_data_in);
      if (cb_cs && cb_rd && !pr) radr.push_back(cb_adr);
      pw = cb_cs && cb_wr;
      pr = cb_cs && cb_rd;
      if (rsp_valid) begin
        rsp_cyc = k;
        break;
      end
      @(posedge busclk); #1;
    end
  endtask

  initial begin
    int acc, rsp, strobes, low_run, min_gap;
    logic seen, w, pw;
    busrst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = 8'h00;
    cmd_value = 16'h0000; cmd_route = 16'h0000;

    // 1. reset
    @(posedge busclk); #1;
    @(posedge busclk); #1;
    check_value("rst_cs", {29'd0, cb_cs, cb_wr, cb_rd}, 32'd0);
    check_value("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_rsp_value", {16'd0, rsp_value}, 32'd0);
    check_value("rst_adr_data", {22'd0, cb_adr, cb_data_in}, 32'd0);
    busrst_n = 1'b1;
    @(posedge busclk); #1;
    check_value("release_ready", {31'd0, cmd_ready}, 32'd1);

    // NOP
    run_cmd(3'd0, 8'h00, 16'h0000, 16'h0000);
    check_value("nop_rsp_cyc", rsp_cyc, 32'd1);
    check_value("nop_no_strobe", wr_hist[31:0] | rd_hist[31:0], 32'd0);

    // 2. LOAD
    run_cmd(3'd1, 8'h00, 16'h1234, 16'h0000);
    check_value("load_setup_adr", {30'd0, s_adr}, 32'd0);
    check_value("load_setup_data", {24'd0, s_data}, 32'h80);
    check_value("load_setup_wide", {16'd0, s_wide}, 32'h1234);
    check_value("load_setup_cs", {31'd0, s_cs}, 32'd0);
    check_value("load_wr_hist", wr_hist[31:0], 32'h0000_000C);
    check_value("load_rsp_cyc", rsp_cyc, 32'd6);
    check_value("load_rsp_value", {16'd0, rsp_value}, 32'd0);

    // 3. LOAD_START
    run_cmd(3'd7, 8'h00, 16'h00FF, 16'h0000);
    check_value("ls_edges", wdata.size(), 32'd2);
    check_value("ls_data0", {24'd0, wdata[0]}, 32'h80);
    check_value("ls_data1", {24'd0, wdata[1]}, 32'h09);
    check_value("ls_wr_hist", wr_hist[31:0], 32'h0000_018C);
    check_value("ls_rsp_cyc", rsp_cyc, 32'd11);
    check_value("ls_wide", {16'd0, cb_wide_data}, 32'h00FF);

    // 4. READ
    run_cmd(3'd6, 8'h00, 16'h0000, 16'h0000);
    check_value("rd_hist", rd_hist[31:0], 32'h0000_018C);
    check_value("rd_no_wr", wr_hist[31:0], 32'd0);
    check_value("rd_strobes", radr.size(), 32'd2);
    check_value("rd_adr0", {30'd0, radr[0]}, 32'd0);
    check_value("rd_adr1", {30'd0, radr[1]}, 32'd1);
    check_value("rd_rsp_cyc", rsp_cyc, 32'd11);
    check_value("rd_rsp_value", {16'd0, rsp_value}, 32'hBEEF);

    // TRIG_ROUTE: data masked to 5 bits, wide data untouched, rsp_value kept
    run_cmd(3'd3, 8'hFF, 16'h0000, 16'hA5C3);
    check_value("tr_adr", {30'd0, s_adr}, 32'd2);
    check_value("tr_data", {24'd0, s_data}, 32'h1F);
    check_value("tr_route", {16'd0, s_route}, 32'hA5C3);
    check_value("tr_wide_hold", {16'd0, s_wide}, 32'h00FF);
    check_value("tr_rsp_value", {16'd0, rsp_value}, 32'hBEEF);

    // CMP_ROUTE: full mask byte
    run_cmd(3'd4, 8'hE7, 16'h0000, 16'h0F0F);
    check_value("cr_adr_data", {22'd0, s_adr, s_data}, {22'd0, 2'd3, 8'hE7});
    check_value("cr_route", {16'd0, s_route}, 32'h0F0F);

    // 5. reset during W_STROBE of a CMP
    @(posedge busclk); #1;
    cmd_op = 3'd2; cmd_mask = 8'h55; cmd_value = 16'hA5A5; cmd_valid = 1'b1;
    @(posedge busclk); #1;   // handshake edge; cycle 1
    cmd_valid = 1'b0;
    @(posedge busclk); #1;   // cycle 2: strobe
    check_value("cmp_strobe", {30'd0, cb_cs, cb_wr}, 32'd3);
    check_value("cmp_adr_data", {22'd0, cb_adr, cb_data_in}, {22'd0, 2'd1, 8'h55});
    busrst_n = 1'b0;
    @(posedge busclk); #1;
    check_value("abort_cs_wr", {30'd0, cb_cs, cb_wr}, 32'd0);
    check_value("abort_rsp", {31'd0, rsp_valid}, 32'd0);
    busrst_n = 1'b1;
    rsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge busclk); #1;
      if (rsp_valid) rsp++;
    end
    check_value("abort_no_rsp", rsp, 32'd0);
    run_cmd(3'd5, 8'hE3, 16'h0000, 16'h0000);
    check_value("post_abort_data", {24'd0, s_data}, 32'h03);
    check_value("post_abort_rsp_cyc", rsp_cyc, 32'd6);

    // 6. cmd_valid held high across back-to-back PULSEs
    @(posedge busclk); #1;
    cmd_op = 3'd5; cmd_mask = 8'h01; cmd_valid = 1'b1;
    acc = 0; rsp = 0; strobes = 0; low_run = 0; min_gap = 1000;
    seen = 1'b0; pw = 1'b0;
    for (int s = 0; s < 21; s++) begin
      if (cmd_valid && cmd_ready) acc++;
      if (rsp_valid) rsp++;
      w = cb_cs && cb_wr;
      if (w && !pw) begin
        if (seen && low_run < min_gap) min_gap = low_run;
        seen = 1'b1;
        strobes++;
      end
      if (w) low_run = 0;
      else   low_run++;
      pw = w;
      @(posedge busclk); #1;
    end
    cmd_valid = 1'b0;
    check_value("b2b_accepts", acc, 32'd3);
    check_value("b2b_rsps", rsp, 32'd3);
    check_value("b2b_strobes", strobes, 32'd3);
    check_value("b2b_min_gap", min_gap, 32'd5);

    repeat (3) @(posedge busclk);
    #1;
    check_value("bus_protocol", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
